regfile_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port (WEN/Add2/InA) of the W-bit, 4-entry register file between N requesters. It accepts one write per cycle, registers the winning write command, and returns a one-cycle grant pulse to the winning requester. It supports optional locked bursts and counts completed writes. It sits directly in front of the register file; read ports (Add0/Add1) are not touched.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wr_arbiter_if.sv | 29 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/regfile_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
// Width parameters match the 4-entry register file the arbiter feeds.
package regfile_pkg;

  localparam int W    = 4;
  localparam int AW   = 2;
  localparam int NREG = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side write bus plus the register-file write port driven by the arbiter.
// The arbiter uses the slave modport; the requesters and register file see the master side.
interface regfile_wr_arbiter_if #(
  parameter int N  = 3,
  parameter int W  = regfile_pkg::W,
  parameter int AW = regfile_pkg::AW
);

  logic [N-1:0]    Req;
  logic [N-1:0]    Lock;
  logic [N*AW-1:0] ReqAdd;
  logic [N*W-1:0]  ReqData;
  logic [N-1:0]    Gnt;
  logic            WEN;
  logic [AW-1:0]   Add2;
  logic [W-1:0]    InA;
  logic [7:0]      WrCnt;

  modport master (
    output Req, Lock, ReqAdd, ReqData,
    input  Gnt, WEN, Add2, InA, WrCnt
  );

  modport slave (
    input  Req, Lock, ReqAdd, ReqData,
    output Gnt, WEN, Add2, InA, WrCnt
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr, else the
// lowest eligible index (the wrap-around part of the scan).
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [N-1:0] upper;
  logic [N-1:0] upperPick;
  logic [N-1:0] lowerPick;
  logic         upperAny;
  logic         lowerAny;

  always_comb begin
    upper     = '0;
    upperPick = '0;
    lowerPick = '0;
    upperAny  = 1'b0;
    lowerAny  = 1'b0;
    for (int i = 0; i < N; i++) begin
      upper[i] = elig[i] && (PW'(i) >= ptr);
    end
    for (int i = 0; i < N; i++) begin
      if (!upperAny && upper[i]) begin
        upperPick[i] = 1'b1;
        upperAny     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!lowerAny && elig[i]) begin
        lowerPick[i] = 1'b1;
        lowerAny     = 1'b1;
      end
    end
    grant = upperAny ? upperPick : lowerPick;
    valid = lowerAny;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with locked bursts
// and a wrapping count of accepted writes.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 3
) (
  input logic                 CLK,
  input logic                 RES,
  regfile_wr_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  arb_state_e    state;
  logic [PW-1:0] ptr;
  logic [N-1:0]  ownerOh;

  logic          ownerReq;
  logic          ownerLock;
  logic          lockDrop;
  logic          holdLock;
  logic [PW-1:0] ownerNext;
  logic [PW-1:0] basePtr;
  logic [N-1:0]  staleMask;
  logic [N-1:0]  elig;

  logic [N-1:0]  winOh;
  logic          winValid;
  logic [PW-1:0] winIdx;
  logic [PW-1:0] winNext;
  logic [AW-1:0] winAdd;
  logic [W-1:0]  winData;
  logic          winLock;

  // A burst ends as soon as the owner lets go of Req or Lock; that same cycle is
  // arbitrated as if unlocked, starting just after the owner.
  always_comb begin
    ownerReq  = |(bus.Req & ownerOh);
    ownerLock = |(bus.Lock & ownerOh);
    lockDrop  = (state == LOCKED) && !(ownerReq && ownerLock);
    holdLock  = (state == LOCKED) && !lockDrop;
    ownerNext = '0;
    for (int i = 0; i < N; i++) begin
      if (ownerOh[i]) begin
        ownerNext = (PW'(i) == LAST) ? '0 : PW'(i + 1);
      end
    end
    basePtr   = lockDrop ? ownerNext : ptr;
    staleMask = bus.Gnt & ~bus.Lock;
    if (lockDrop) begin
      staleMask = staleMask & ~ownerOh;
    end
    elig = holdLock ? ownerOh : (bus.Req & ~staleMask);
  end

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .elig  (elig),
    .ptr   (basePtr),
    .grant (winOh),
    .valid (winValid)
  );

  always_comb begin
    winIdx  = '0;
    winAdd  = '0;
    winData = '0;
    winLock = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (winOh[i]) begin
        winIdx  = PW'(i);
        winAdd  = bus.ReqAdd[i*AW +: AW];
        winData = bus.ReqData[i*W +: W];
        winLock = bus.Lock[i];
      end
    end
    winNext = (winIdx == LAST) ? '0 : winIdx + 1'b1;
  end

  // Reset drops any registered-but-unwritten word by clearing WEN immediately.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= ARB;
      ptr       <= '0;
      ownerOh   <= '0;
      bus.Gnt   <= '0;
      bus.WEN   <= 1'b0;
      bus.Add2  <= '0;
      bus.InA   <= '0;
      bus.WrCnt <= '0;
    end else begin
      bus.WEN <= winValid;
      bus.Gnt <= winOh;
      if (winValid) begin
        bus.Add2  <= winAdd;
        bus.InA   <= winData;
        bus.WrCnt <= bus.WrCnt + 8'd1;
      end
      if (!holdLock) begin
        if (winValid) begin
          ptr <= winNext;
          if (winLock) begin
            state   <= LOCKED;
            ownerOh <= winOh;
          end else begin
            state <= ARB;
          end
        end else begin
          state <= ARB;
          ptr   <= basePtr;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scenario bench for regfile_wr_arbiter with a behavioural arbitration model and a
// simple register-file stand-in that captures every issued write.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int W  = 4;
  localparam int AW = 2;
  localparam int NR = regfile_pkg::NREG;

  logic CLK = 1'b0;
  logic RES;

  always #5 CLK = ~CLK;

  regfile_wr_arbiter_if #(.N(N), .W(W), .AW(AW)) bus ();

  regfile_wr_arbiter #(.N(N)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  logic [W-1:0] rf [NR];

  always @(posedge CLK) begin
    if (bus.WEN) rf[bus.Add2] <= bus.InA;
  end

  int            mPtr;
  bit            mLocked;
  int            mOwner;
  logic [N-1:0]  eGnt;
  logic          eWen;
  logic [AW-1:0] eAdd;
  logic [W-1:0]  eData;
  logic [7:0]    eCnt;
  logic [W-1:0]  memExp [NR];
  bit            memKnown [NR];

  int checks = 0;
  int errors = 0;

  task automatic modelReset();
    mPtr = 0; mLocked = 0; mOwner = 0;
    eGnt = '0; eWen = 1'b0; eAdd = '0; eData = '0; eCnt = '0;
  endtask

  // Predict the arbiter's next registered outputs from the arbitration rules, then clock.
  task automatic advance();
    logic [N-1:0]  elig;
    logic [AW-1:0] sAdd;
    logic [W-1:0]  sData;
    bit            sLock, drop, hold;
    int            win, base, idx;
    drop = mLocked && !(bus.Req[mOwner] && bus.Lock[mOwner]);
    hold = mLocked && !drop;
    base = drop ? (mOwner + 1) % N : mPtr;
    for (int i = 0; i < N; i++)
      elig[i] = hold ? (i == mOwner)
                     : (bus.Req[i] && !(eGnt[i] && !bus.Lock[i] && !(drop && i == mOwner)));
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (base + k) % N;
      if (win < 0 && elig[idx]) win = idx;
    end
    sAdd = '0; sData = '0; sLock = 0;
    if (win >= 0) begin
      sAdd  = bus.ReqAdd[win*AW +: AW];
      sData = bus.ReqData[win*W +: W];
      sLock = bus.Lock[win];
    end
    if (eWen) begin
      memExp[eAdd]   = eData;
      memKnown[eAdd] = 1'b1;
    end
    @(posedge CLK);
    #1;
    eWen = (win >= 0);
    eGnt = '0;
    if (win >= 0) begin
      eGnt[win] = 1'b1;
      eAdd  = sAdd;
      eData = sData;
      eCnt  = eCnt + 8'd1;
    end
    if (!hold) begin
      if (win >= 0) begin
        mPtr    = (win + 1) % N;
        mLocked = sLock;
        if (sLock) mOwner = win;
      end else begin
        mLocked = 0;
        mPtr    = base;
      end
    end
  endtask

  task automatic clearInputs();
    bus.Req = '0; bus.Lock = '0; bus.ReqAdd = '0; bus.ReqData = '0;
  endtask

  task automatic doReset();
    #2;
    RES = 1'b1;
    clearInputs();
    modelReset();
    @(posedge CLK);
    #1;
    RES = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset: got wen=%b gnt=%b add=%0d data=%h cnt=%0d want all zero",
               bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt);
    end
    RES = 1'b0;
  endtask

  task automatic test_single_request();
    bus.Req = 3'b001; bus.ReqAdd = 6'b000010; bus.ReqData = 12'h00C;
    advance();
    checks++;
    if ({bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt} !== {1'b1, 3'b001, 2'd2, 4'hC, 8'd1}) begin
      errors++;
      $display("[TB] FAIL single: got wen=%b gnt=%b add=%0d data=%h cnt=%0d want 1/001/2/c/1",
               bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt);
    end
    clearInputs();
    advance();
    checks++;
    if (rf[2] !== 4'hC) begin
      errors++;
      $display("[TB] FAIL single_rf: got rf[2]=%h want c", rf[2]);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] expSeq [4];
    expSeq = '{3'b001, 3'b010, 3'b100, 3'b001};
    doReset();
    bus.Req = 3'b111; bus.ReqAdd = {2'd2, 2'd1, 2'd0}; bus.ReqData = {4'hD, 4'hB, 4'hA};
    for (int c = 0; c < 4; c++) begin
      advance();
      checks++;
      if ({bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt} !== {eWen, eGnt, eAdd, eData, eCnt}
          || bus.Gnt !== expSeq[c]) begin
        errors++;
        $display("[TB] FAIL rr_%0d: got wen=%b gnt=%b add=%0d data=%h cnt=%0d want wen=%b gnt=%b add=%0d data=%h cnt=%0d",
                 c, bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt, 1'b1, expSeq[c], eAdd, eData, eCnt);
      end
    end
    clearInputs();
    advance();
    checks++;
    if (rf[0] !== 4'hA || rf[1] !== 4'hB || rf[2] !== 4'hD) begin
      errors++;
      $display("[TB] FAIL rr_rf: got %h %h %h want a b d", rf[0], rf[1], rf[2]);
    end
  endtask

  task automatic test_locked_burst();
    logic [N-1:0] expTail [2];
    expTail = '{3'b100, 3'b001};
    doReset();
    bus.Req = 3'b001; bus.ReqAdd = 6'b000011; bus.ReqData = 12'h001;
    advance();
    bus.Req = 3'b111; bus.Lock = 3'b010;
    for (int k = 0; k < 4; k++) begin
      bus.ReqAdd  = {2'd3, AW'(k), 2'd3};
      bus.ReqData = {4'h5, W'(8 + k), 4'h6};
      advance();
      checks++;
      if (bus.Gnt !== 3'b010 || {bus.WEN, bus.Add2, bus.InA, bus.WrCnt} !== {eWen, eAdd, eData, eCnt}) begin
        errors++;
        $display("[TB] FAIL burst_%0d: got gnt=%b wen=%b add=%0d data=%h cnt=%0d want gnt=010 wen=%b add=%0d data=%h cnt=%0d",
                 k, bus.Gnt, bus.WEN, bus.Add2, bus.InA, bus.WrCnt, eWen, eAdd, eData, eCnt);
      end
    end
    bus.Req = 3'b101; bus.Lock = 3'b000;
    for (int k = 0; k < 2; k++) begin
      advance();
      checks++;
      if (bus.Gnt !== expTail[k] || bus.Gnt !== eGnt || bus.WrCnt !== eCnt) begin
        errors++;
        $display("[TB] FAIL burst_release_%0d: got gnt=%b cnt=%0d want gnt=%b cnt=%0d",
                 k, bus.Gnt, bus.WrCnt, expTail[k], eCnt);
      end
    end
    clearInputs();
    advance();
    checks++;
    if (rf[0] !== 4'h8 || rf[1] !== 4'h9 || rf[2] !== 4'hA || rf[3] !== memExp[3]) begin
      errors++;
      $display("[TB] FAIL burst_rf: got %h %h %h %h want 8 9 a %h", rf[0], rf[1], rf[2], rf[3], memExp[3]);
    end
  endtask

  task automatic test_no_stale_regrant();
    logic [7:0] cntBefore;
    doReset();
    cntBefore = eCnt;
    bus.Req = 3'b001; bus.ReqAdd = 6'b000001; bus.ReqData = 12'h007;
    advance();
    advance();
    checks++;
    if (bus.Gnt !== 3'b000 || bus.WEN !== 1'b0 || bus.Gnt !== eGnt) begin
      errors++;
      $display("[TB] FAIL stale: got gnt=%b wen=%b want gnt=000 wen=0", bus.Gnt, bus.WEN);
    end
    clearInputs();
    advance();
    checks++;
    if (bus.WrCnt !== cntBefore + 8'd1) begin
      errors++;
      $display("[TB] FAIL stale_cnt: got %0d want %0d", bus.WrCnt, cntBefore + 8'd1);
    end
  endtask

  task automatic test_async_reset_mid_burst();
    doReset();
    bus.Req = 3'b100; bus.ReqAdd = 6'b010000; bus.ReqData = 12'h500;
    advance();
    bus.Req = 3'b001; bus.Lock = 3'b001; bus.ReqAdd = 6'b000001; bus.ReqData = 12'h006;
    advance();
    bus.ReqData = 12'h007;
    advance();
    #2;
    RES = 1'b1;
    #1;
    checks++;
    if (bus.WEN !== 1'b0 || bus.Gnt !== 3'b000 || bus.WrCnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got wen=%b gnt=%b cnt=%0d want 0/000/0", bus.WEN, bus.Gnt, bus.WrCnt);
    end
    clearInputs();
    modelReset();
    @(posedge CLK);
    #1;
    RES = 1'b0;
    checks++;
    if (rf[1] !== 4'h6) begin
      errors++;
      $display("[TB] FAIL async_drop: got rf[1]=%h want 6", rf[1]);
    end
    bus.Req = 3'b101; bus.ReqAdd = 6'b100011; bus.ReqData = 12'h403;
    advance();
    checks++;
    if (bus.Gnt !== 3'b001 || bus.Gnt !== eGnt) begin
      errors++;
      $display("[TB] FAIL post_reset_ptr: got gnt=%b want 001", bus.Gnt);
    end
    bus.Req = 3'b100; bus.ReqData = 12'hE00;
    advance();
    checks++;
    if (bus.Gnt !== 3'b100 || bus.WrCnt !== 8'd2 || bus.InA !== 4'hE || bus.Add2 !== 2'd2) begin
      errors++;
      $display("[TB] FAIL post_reset_req2: got gnt=%b cnt=%0d data=%h add=%0d want 100/2/e/2",
               bus.Gnt, bus.WrCnt, bus.InA, bus.Add2);
    end
    clearInputs();
    advance();
  endtask

  task automatic test_random();
    int bad;
    doReset();
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      bus.Req     = N'($urandom);
      bus.Lock    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      bus.ReqAdd  = (N*AW)'($urandom);
      bus.ReqData = (N*W)'($urandom);
      advance();
      checks++;
      if ({bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt} !== {eWen, eGnt, eAdd, eData, eCnt}) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("[TB] FAIL random_%0d: got wen=%b gnt=%b add=%0d data=%h cnt=%0d want wen=%b gnt=%b add=%0d data=%h cnt=%0d",
                   c, bus.WEN, bus.Gnt, bus.Add2, bus.InA, bus.WrCnt, eWen, eGnt, eAdd, eData, eCnt);
      end
    end
    clearInputs();
    advance();
    for (int a = 0; a < NR; a++) begin
      if (memKnown[a]) begin
        checks++;
        if (rf[a] !== memExp[a]) begin
          errors++;
          $display("[TB] FAIL random_rf%0d: got %h want %h", a, rf[a], memExp[a]);
        end
      end
    end
  endtask

  task automatic test_wrcnt_wrap();
    doReset();
    bus.Req = 3'b001; bus.Lock = 3'b001;
    for (int c = 0; c < 256; c++) begin
      bus.ReqAdd  = (N*AW)'($urandom);
      bus.ReqData = (N*W)'($urandom);
      advance();
      if (c == 254) begin
        checks++;
        if (bus.WrCnt !== 8'd255) begin
          errors++;
          $display("[TB] FAIL wrcnt_255: got %0d want 255", bus.WrCnt);
        end
      end
    end
    checks++;
    if (bus.WrCnt !== 8'd0 || bus.WrCnt !== eCnt || bus.WEN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrcnt_wrap: got cnt=%0d wen=%b want cnt=0 wen=1", bus.WrCnt, bus.WEN);
    end
    clearInputs();
    advance();
  endtask

  initial begin
    RES = 1'b1;
    clearInputs();
    modelReset();
    for (int a = 0; a < NR; a++) memKnown[a] = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_single_request();
    test_round_robin();
    test_locked_burst();
    test_no_stale_regrant();
    test_async_reset_mid_burst();
    test_random();
    test_wrcnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
